// File: rtl/ifu_prefetch_if.sv
// Fetch-unit bus: redirect input, instruction RAM port and decoder handshake.
// master = fetch unit side, slave = surrounding core / RAM side.
interface ifu_prefetch_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 6
);
    logic              IFU_PF_redirect;
    logic [XLEN-1:0]   IFU_PF_redirect_pc;
    logic              IFU_PF_ram_en;
    logic [ADDR_W-1:0] IFU_PF_ram_addr;
    logic [XLEN-1:0]   IFU_PF_ram_data;
    logic [XLEN-1:0]   IFU_PF_ins;
    logic [XLEN-1:0]   IFU_PF_ins_pc;
    logic              IFU_PF_ins_valid;
    logic              IFU_PF_ins_ready;
    logic              IFU_PF_misaligned;

    modport master (
        input  IFU_PF_redirect, IFU_PF_redirect_pc, IFU_PF_ram_data, IFU_PF_ins_ready,
        output IFU_PF_ram_en, IFU_PF_ram_addr, IFU_PF_ins, IFU_PF_ins_pc,
               IFU_PF_ins_valid, IFU_PF_misaligned
    );

    modport slave (
        output IFU_PF_redirect, IFU_PF_redirect_pc, IFU_PF_ram_data, IFU_PF_ins_ready,
        input  IFU_PF_ram_en, IFU_PF_ram_addr, IFU_PF_ins, IFU_PF_ins_pc,
               IFU_PF_ins_valid, IFU_PF_misaligned
    );
endinterface

// File: rtl/ifu_prefetch.sv
// Instruction fetch unit: runs its own fetch PC against a synchronous-read RAM
// and buffers returned words with their PCs in a DEPTH-entry prefetch queue.
module ifu_prefetch #(
    parameter int unsigned    XLEN     = 32,
    parameter int unsigned    ADDR_W   = 6,
    parameter int unsigned    DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic           IFU_PF_clk,
    input  logic           IFU_PF_rst,
    ifu_prefetch_if.master bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {ST_RUN, ST_HALT} state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   fpc_q, fpc_d;
    logic [XLEN-1:0]   tag_q, tag_d;
    logic              inflight_q, inflight_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [XLEN-1:0]   ins_mem_q [DEPTH];
    logic [XLEN-1:0]   ins_mem_d [DEPTH];
    logic [XLEN-1:0]   pc_mem_q  [DEPTH];
    logic [XLEN-1:0]   pc_mem_d  [DEPTH];

    logic              valid_c;
    logic              pop_c;
    logic              issue_c;
    logic [CNT_W:0]    credit_c;

    // Credit counts the in-flight word and frees the slot of a same-cycle pop.
    assign valid_c  = ~IFU_PF_rst & (count_q != '0);
    assign pop_c    = valid_c & bus.IFU_PF_ins_ready;
    assign credit_c = {1'b0, count_q} + (CNT_W + 1)'(inflight_q) - (CNT_W + 1)'(pop_c);
    assign issue_c  = (state_q == ST_RUN) & ~bus.IFU_PF_redirect & ~IFU_PF_rst &
                      (credit_c < (CNT_W + 1)'(DEPTH));

    assign bus.IFU_PF_ram_en     = issue_c;
    assign bus.IFU_PF_ram_addr   = fpc_q[ADDR_W+1:2];
    assign bus.IFU_PF_ins_valid  = valid_c;
    assign bus.IFU_PF_ins        = IFU_PF_rst ? '0 : ins_mem_q[rd_ptr_q];
    assign bus.IFU_PF_ins_pc     = IFU_PF_rst ? '0 : pc_mem_q[rd_ptr_q];
    assign bus.IFU_PF_misaligned = ~IFU_PF_rst & (state_q == ST_HALT);

    // Next-state: redirect flushes everything, otherwise issue / push / pop.
    always_comb begin
        state_d    = state_q;
        fpc_d      = fpc_q;
        tag_d      = tag_q;
        inflight_d = inflight_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        ins_mem_d  = ins_mem_q;
        pc_mem_d   = pc_mem_q;

        if (bus.IFU_PF_redirect) begin
            count_d    = '0;
            inflight_d = 1'b0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            fpc_d      = bus.IFU_PF_redirect_pc;
            state_d    = (bus.IFU_PF_redirect_pc[1:0] != 2'b00) ? ST_HALT : ST_RUN;
        end else begin
            inflight_d = issue_c;
            if (issue_c) begin
                fpc_d = fpc_q + XLEN'(4);
                tag_d = fpc_q;
            end
            if (inflight_q) begin
                ins_mem_d[wr_ptr_q] = bus.IFU_PF_ram_data;
                pc_mem_d[wr_ptr_q]  = tag_q;
                wr_ptr_d            = wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(inflight_q) - CNT_W'(pop_c);
        end
    end

    always_ff @(posedge IFU_PF_clk) begin
        if (IFU_PF_rst) begin
            state_q    <= ST_RUN;
            fpc_q      <= RESET_PC;
            tag_q      <= '0;
            inflight_q <= 1'b0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                ins_mem_q[i] <= '0;
                pc_mem_q[i]  <= '0;
            end
        end else begin
            state_q    <= state_d;
            fpc_q      <= fpc_d;
            tag_q      <= tag_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            ins_mem_q  <= ins_mem_d;
            pc_mem_q   <= pc_mem_d;
        end
    end
endmodule

// File: tb/tb_ifu_prefetch.sv
// Bench for ifu_prefetch: directed scenarios followed by randomized redirect /
// backpressure traffic, scored against an expected in-order PC stream.
module tb_ifu_prefetch;
    localparam int unsigned XLEN     = 32;
    localparam int unsigned ADDR_W   = 6;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ifu_prefetch_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus ();

    ifu_prefetch #(.XLEN(XLEN), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .IFU_PF_clk (clk),
        .IFU_PF_rst (rst),
        .bus        (bus.master)
    );

    always #5 clk = ~clk;

    // Synchronous-read instruction RAM.
    logic [31:0] ram [64];
    always @(posedge clk) begin
        if (bus.IFU_PF_ram_en) bus.IFU_PF_ram_data <= ram[bus.IFU_PF_ram_addr];
    end

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_pc   = 32'h0;
    bit          halted   = 1'b0;
    int          since    = 0;
    int          pulses;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // One cycle: drive inputs after the edge, then score outputs against the model.
    task automatic tick(input bit r, input bit rdy, input bit rd, input logic [31:0] rpc);
        @(posedge clk);
        #2;
        rst                    = r;
        bus.IFU_PF_ins_ready   = rdy;
        bus.IFU_PF_redirect    = rd;
        bus.IFU_PF_redirect_pc = rpc;
        #1;
        if (r) begin
            check("rst_valid",  32'(bus.IFU_PF_ins_valid), 32'(0));
            check("rst_ram_en", 32'(bus.IFU_PF_ram_en), 32'(0));
            check("rst_ins",    bus.IFU_PF_ins, 32'h0);
            check("rst_ins_pc", bus.IFU_PF_ins_pc, 32'h0);
            check("rst_misal",  32'(bus.IFU_PF_misaligned), 32'(0));
            exp_pc = RESET_PC;
            halted = 1'b0;
            since  = 0;
        end else begin
            if (since < 1000) since++;
            if (halted) begin
                check("halt_misal",  32'(bus.IFU_PF_misaligned), 32'(1));
                check("halt_valid",  32'(bus.IFU_PF_ins_valid), 32'(0));
                check("halt_ram_en", 32'(bus.IFU_PF_ram_en), 32'(0));
            end else begin
                check("run_misal", 32'(bus.IFU_PF_misaligned), 32'(0));
                check("run_valid", 32'(bus.IFU_PF_ins_valid), 32'(since >= 3));
            end
            if (rd) begin
                check("redir_ram_en", 32'(bus.IFU_PF_ram_en), 32'(0));
                exp_pc = rpc;
                halted = (rpc[1:0] != 2'b00);
                since  = 0;
            end else if (!halted && bus.IFU_PF_ins_valid && rdy) begin
                check("pop_pc",  bus.IFU_PF_ins_pc, exp_pc);
                check("pop_ins", bus.IFU_PF_ins, ram[exp_pc[ADDR_W+1:2]]);
                exp_pc = exp_pc + 32'd4;
            end
        end
    endtask

    initial begin
        logic [31:0] rpc;
        bit          r, rd, rdy;

        for (int i = 0; i < 64; i++) ram[i] = 32'h1000_0000 + 32'(i);
        bus.IFU_PF_ins_ready   = 1'b0;
        bus.IFU_PF_redirect    = 1'b0;
        bus.IFU_PF_redirect_pc = 32'h0;

        // Reset release with ready high: 2-cycle latency, then one per cycle.
        repeat (3) tick(1'b1, 1'b1, 1'b0, 32'h0);
        tick(1'b0, 1'b1, 1'b0, 32'h0);
        check("c0_ram_en", 32'(bus.IFU_PF_ram_en), 32'(1));
        check("c0_ram_addr", 32'(bus.IFU_PF_ram_addr), 32'(0));
        tick(1'b0, 1'b1, 1'b0, 32'h0);
        tick(1'b0, 1'b1, 1'b0, 32'h0);
        check("c2_ins", bus.IFU_PF_ins, 32'h1000_0000);
        check("c2_pc", bus.IFU_PF_ins_pc, 32'h0);
        repeat (10) tick(1'b0, 1'b1, 1'b0, 32'h0);

        // Backpressure from reset: exactly DEPTH requests at addresses 0..DEPTH-1.
        repeat (2) tick(1'b1, 1'b0, 1'b0, 32'h0);
        pulses = 0;
        repeat (12) begin
            tick(1'b0, 1'b0, 1'b0, 32'h0);
            if (bus.IFU_PF_ram_en) begin
                check("bp_addr", 32'(bus.IFU_PF_ram_addr), 32'(pulses));
                pulses++;
            end
        end
        check("bp_pulses", 32'(pulses), 32'(DEPTH));
        check("bp_head_ins", bus.IFU_PF_ins, 32'h1000_0000);
        check("bp_head_pc", bus.IFU_PF_ins_pc, 32'h0);
        tick(1'b0, 1'b1, 1'b0, 32'h0);
        check("refill_en", 32'(bus.IFU_PF_ram_en), 32'(1));
        check("refill_addr", 32'(bus.IFU_PF_ram_addr), 32'(DEPTH));
        repeat (8) tick(1'b0, 1'b1, 1'b0, 32'h0);

        // Redirect with 3 queued entries and one in flight; pending pop discarded.
        tick(1'b1, 1'b0, 1'b0, 32'h0);
        repeat (4) tick(1'b0, 1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b1, 1'b1, 32'h40);
        tick(1'b0, 1'b1, 1'b0, 32'h0);
        check("rd_n1_en", 32'(bus.IFU_PF_ram_en), 32'(1));
        check("rd_n1_addr", 32'(bus.IFU_PF_ram_addr), 32'(16));
        tick(1'b0, 1'b1, 1'b0, 32'h0);
        tick(1'b0, 1'b1, 1'b0, 32'h0);
        check("rd_n3_ins", bus.IFU_PF_ins, 32'h1000_0010);
        check("rd_n3_pc", bus.IFU_PF_ins_pc, 32'h40);
        repeat (4) tick(1'b0, 1'b1, 1'b0, 32'h0);

        // Misaligned redirect halts; a second misaligned one keeps it halted.
        tick(1'b0, 1'b1, 1'b1, 32'h42);
        repeat (10) tick(1'b0, 1'b1, 1'b0, 32'h0);
        tick(1'b0, 1'b1, 1'b1, 32'h46);
        repeat (2) tick(1'b0, 1'b1, 1'b0, 32'h0);
        tick(1'b0, 1'b1, 1'b1, 32'h80);
        tick(1'b0, 1'b1, 1'b0, 32'h0);
        check("unhalt_en", 32'(bus.IFU_PF_ram_en), 32'(1));
        check("unhalt_addr", 32'(bus.IFU_PF_ram_addr), 32'(32));
        tick(1'b0, 1'b1, 1'b0, 32'h0);
        tick(1'b0, 1'b1, 1'b0, 32'h0);
        check("unhalt_ins", bus.IFU_PF_ins, 32'h1000_0020);
        repeat (3) tick(1'b0, 1'b1, 1'b0, 32'h0);

        // RAM address wrap past the top of the 64-word array.
        tick(1'b0, 1'b1, 1'b1, 32'hF8);
        for (int k = 0; k < 4; k++) begin
            tick(1'b0, 1'b1, 1'b0, 32'h0);
            check("wrap_en", 32'(bus.IFU_PF_ram_en), 32'(1));
            check("wrap_addr", 32'(bus.IFU_PF_ram_addr), 32'((62 + k) % 64));
        end
        repeat (4) tick(1'b0, 1'b1, 1'b0, 32'h0);

        // Single-cycle reset with a partly filled queue.
        repeat (2) tick(1'b0, 1'b0, 1'b0, 32'h0);
        tick(1'b1, 1'b0, 1'b0, 32'h0);
        repeat (3) tick(1'b0, 1'b1, 1'b0, 32'h0);
        check("rst_restart_pc", bus.IFU_PF_ins_pc, 32'h0);
        repeat (3) tick(1'b0, 1'b1, 1'b0, 32'h0);

        // Randomized traffic: backpressure, redirects (aligned, misaligned, near 2^32), resets.
        for (int n = 0; n < 1500; n++) begin
            r   = ($urandom_range(0, 199) == 0);
            rd  = ($urandom_range(0, 24) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            rpc = $urandom;
            case ($urandom_range(0, 4))
                0:       rpc[1:0] = 2'($urandom_range(1, 3));
                1:       rpc = 32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3));
                default: rpc[1:0] = 2'b00;
            endcase
            tick(r, rdy, rd, rpc);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
